// File: rtl/rhythm_map_recorder_pkg.sv
// Shared rhythm package: recorder/playback FSM encoding and the default map length.
package rhythm_map_recorder_pkg;

    // State encoding shared with the playback datapath.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DONE   = 2'd2
    } rec_state_t;

    // Default number of 8 Hz slots in a rhythm map.
    localparam int MAP_LEN_DEFAULT = 191;

endpackage

// File: rtl/rhythm_map_recorder_button_debouncer.sv
// Push-key conditioning: 2-flop synchroniser followed by a stability counter.
// The debounced level only follows the synchronised input after it has disagreed
// for DEBOUNCE_CYCLES consecutive clocks; a one-clock press pulse marks each
// debounced 1->0 transition.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic in_n,
    output logic level_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key into the clk domain; idle level is "released".
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= in_n;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing clocks; flip the level when the count completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_n <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 != level_n) begin
                if (cnt == CNT_LAST) begin
                    level_n <= sync2;
                    cnt     <= '0;
                    press   <= ~sync2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rhythm_map_recorder.sv
// Rhythm map recorder: captures debounced key presses into a MAP_LEN-bit map,
// one bit per tick slot, slot 0 ending up in bit 0 for the playback datapath.
module rhythm_map_recorder
    import rhythm_map_recorder_pkg::*;
#(
    parameter int MAP_LEN         = MAP_LEN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start_n,
    input  logic               button_n,
    output logic [MAP_LEN-1:0] map_out,
    output logic               map_valid,
    output logic               recording,
    output logic [7:0]         slot_index,
    output logic [7:0]         note_count
);

    localparam logic [7:0] LAST_SLOT = 8'(MAP_LEN - 1);

    rec_state_t state;
    rec_state_t state_next;
    logic       start_prev;
    logic       start_edge;
    logic       press;
    logic       pending;
    logic       hit;
    logic       last_tick;

    // Note counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .in_n   (button_n),
        .level_n(),
        .press  (press)
    );

    // Remember the previous KEY level so a 1->0 transition can be detected.
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_prev <= 1'b1;
        end else begin
            start_prev <= start_n;
        end
    end

    assign start_edge = start_prev & ~start_n;
    assign hit        = pending | press;
    assign last_tick  = (slot_index == LAST_SLOT);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an abort beats a coincident tick.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_edge) state_next = RECORD;
            RECORD: begin
                if (start_edge)             state_next = IDLE;
                else if (tick && last_tick) state_next = DONE;
            end
            DONE:    if (start_edge) state_next = RECORD;
            default: state_next = IDLE;
        endcase
    end

    // Map shift register, pending flag, counters and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            map_out    <= '0;
            map_valid  <= 1'b0;
            recording  <= 1'b0;
            slot_index <= 8'd0;
            note_count <= 8'd0;
            pending    <= 1'b0;
        end else begin
            unique case (state)
                RECORD: begin
                    if (start_edge) begin
                        map_out    <= '0;
                        map_valid  <= 1'b0;
                        recording  <= 1'b0;
                        slot_index <= 8'd0;
                        note_count <= 8'd0;
                        pending    <= 1'b0;
                    end else if (tick) begin
                        map_out    <= {hit, map_out[MAP_LEN-1:1]};
                        pending    <= 1'b0;
                        slot_index <= slot_index + 8'd1;
                        if (hit) note_count <= sat_inc(note_count);
                        if (last_tick) begin
                            map_valid <= 1'b1;
                            recording <= 1'b0;
                        end
                    end else if (press) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    if (start_edge) begin
                        map_out    <= '0;
                        map_valid  <= 1'b0;
                        recording  <= 1'b1;
                        slot_index <= 8'd0;
                        note_count <= 8'd0;
                        pending    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rhythm_map_recorder.sv
// Scoreboard bench for rhythm_map_recorder (MAP_LEN=8, DEBOUNCE_CYCLES=4, tick every 20 clks).
// Expected end-of-recording snapshots are queued as stimulus is issued; a monitor
// compares outputs each time the recorder leaves RECORD.
module tb_rhythm_map_recorder;

    localparam int MAP_LEN = 8;
    localparam int DEB     = 4;
    localparam int SLOT    = 20;

    logic         clk;
    logic         rst;
    logic         tick;
    logic         start_n;
    logic         button_n;
    logic [7:0]   map_out;
    logic         map_valid;
    logic         recording;
    logic [7:0]   slot_index;
    logic [7:0]   note_count;

    typedef struct {
        logic [7:0] map;
        logic       valid;
        logic [7:0] nc;
        logic [7:0] si;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic rec_prev = 1'b0;

    rhythm_map_recorder #(
        .MAP_LEN        (MAP_LEN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start_n   (start_n),
        .button_n  (button_n),
        .map_out   (map_out),
        .map_valid (map_valid),
        .recording (recording),
        .slot_index(slot_index),
        .note_count(note_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] m, input logic v, input logic [7:0] nc, input logic [7:0] si);
        exp_t e;
        e.map = m; e.valid = v; e.nc = nc; e.si = si;
        q.push_back(e);
    endtask

    // Monitor: every time recording drops, compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (rec_prev && !recording) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_end: recording fell with no expectation queued, map=%0h", map_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("map_out",    map_out,           e.map);
                check("map_valid",  {7'd0, map_valid}, {7'd0, e.valid});
                check("note_count", note_count,        e.nc);
                check("slot_index", slot_index,        e.si);
            end
        end
        rec_prev = recording;
    end

    task automatic do_start();
        @(negedge clk); start_n = 1'b0;
        @(negedge clk); start_n = 1'b1;
    endtask

    // One slot of SLOT clocks, tick on the last; button_n low for [p, p+l) of each window.
    task automatic run_slot(input int p1, input int l1, input int p2, input int l2, input bit abort_on_tick);
        for (int k = 0; k < SLOT; k++) begin
            @(negedge clk);
            tick     = (k == SLOT - 1);
            button_n = !((p1 >= 0 && k >= p1 && k < p1 + l1) ||
                         (p2 >= 0 && k >= p2 && k < p2 + l2));
            if (abort_on_tick) start_n = !(k == SLOT - 1);
        end
    endtask

    task automatic end_slots();
        @(negedge clk);
        tick = 1'b0; start_n = 1'b1; button_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; start_n = 1'b1; button_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_map_out",    map_out,           8'd0);
        check("rst_map_valid",  {7'd0, map_valid}, 8'd0);
        check("rst_recording",  {7'd0, recording}, 8'd0);
        check("rst_slot_index", slot_index,        8'd0);
        check("rst_note_count", note_count,        8'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: reset mid-recording clears everything
        push(8'd0, 1'b0, 8'd0, 8'd0);
        do_start();
        run_slot(2, 5, -1, 0, 1'b0);
        run_slot(-1, 0, -1, 0, 1'b0);
        @(negedge clk); tick = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 2: clean presses in slots 0, 3, 7
        push(8'b1000_1001, 1'b1, 8'd3, 8'd8);
        do_start();
        for (int s = 0; s < MAP_LEN; s++)
            run_slot((s == 0 || s == 3 || s == 7) ? 2 : -1, 5, -1, 0, 1'b0);
        end_slots();

        // 3: 3-clk glitch in slot 2 is rejected
        push(8'd0, 1'b1, 8'd0, 8'd8);
        do_start();
        for (int s = 0; s < MAP_LEN; s++)
            run_slot((s == 2) ? 2 : -1, 3, -1, 0, 1'b0);
        end_slots();

        // 4: two clean presses in slot 1 record a single hit
        push(8'b0000_0010, 1'b1, 8'd1, 8'd8);
        do_start();
        for (int s = 0; s < MAP_LEN; s++)
            run_slot((s == 1) ? 0 : -1, 4, (s == 1) ? 10 : -1, 4, 1'b0);
        end_slots();

        // 5: press pulse lands on the slot-4 tick clock
        push(8'b0001_0000, 1'b1, 8'd1, 8'd8);
        do_start();
        for (int s = 0; s < MAP_LEN; s++)
            run_slot((s == 4) ? SLOT - 1 - (DEB + 2) : -1, 4, -1, 0, 1'b0);
        end_slots();

        // 6: abort on a tick clock, then a full empty recording
        push(8'd0, 1'b0, 8'd0, 8'd0);
        do_start();
        for (int s = 0; s < 3; s++) run_slot(-1, 0, -1, 0, 1'b0);
        run_slot(-1, 0, -1, 0, 1'b1);
        end_slots();
        push(8'd0, 1'b1, 8'd0, 8'd8);
        do_start();
        for (int s = 0; s < MAP_LEN; s++) run_slot(-1, 0, -1, 0, 1'b0);
        end_slots();

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected recording ends never seen, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
